// File: rtl/led_pwm_sequencer.sv
// LED pattern sequencer: accepts one request, then shows the pattern PWM-gated
// at the requested duty for dwell PWM periods before returning to idle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, in_ready high, LEDs dark
// SHOW  | displaying captured pattern, pwm/period counters running
module led_pwm_sequencer #(
   parameter int W_LED   = 4,
   parameter int PWM_W   = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W_LED-1:0]   in_pattern,
   input  logic [PWM_W-1:0]   in_duty,
   input  logic [DWELL_W-1:0] in_dwell,
   output logic [W_LED-1:0]   led,
   output logic               busy,
   output logic               done
);

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

   localparam logic [PWM_W-1:0]   PWM_MAX   = '1;
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   state_t             state;
   state_t             state_nxt;
   logic [PWM_W-1:0]   pwm_cnt;
   logic [DWELL_W-1:0] period_cnt;
   logic [W_LED-1:0]   pattern_q;
   logic [PWM_W-1:0]   duty_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_eff;
   logic               accept;
   logic               last_cycle;

   // A zero dwell still shows one full period.
   assign dwell_eff  = (dwell_q == '0) ? DWELL_ONE : dwell_q;
   assign accept     = (state == IDLE) && in_valid;
   assign last_cycle = (state == SHOW) && (pwm_cnt == PWM_MAX)
                       && (period_cnt == dwell_eff - DWELL_ONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = SHOW;
         SHOW: if (last_cycle) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state == SHOW);
      led      = '0;
      if ((state == SHOW) && (pwm_cnt < duty_q)) begin
         led = pattern_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_cnt    <= '0;
         period_cnt <= '0;
         pattern_q  <= '0;
         duty_q     <= '0;
         dwell_q    <= '0;
         done       <= 1'b0;
      end else begin
         done <= last_cycle;
         if (accept) begin
            pattern_q  <= in_pattern;
            duty_q     <= in_duty;
            dwell_q    <= in_dwell;
            pwm_cnt    <= '0;
            period_cnt <= '0;
         end else if (state == SHOW) begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            // Clearing on the final cycle keeps period_cnt bounded below dwell.
            if (last_cycle) begin
               period_cnt <= '0;
            end else if (pwm_cnt == PWM_MAX) begin
               period_cnt <= period_cnt + DWELL_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer at W_LED=4, PWM_W=3 (P=8), DWELL_W=4.
module tb_led_pwm_sequencer;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_pattern;
   logic [2:0] in_duty;
   logic [3:0] in_dwell;
   logic [3:0] led;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   led_pwm_sequencer #(.W_LED(4), .PWM_W(3), .DWELL_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pattern(in_pattern),
      .in_duty   (in_duty),
      .in_dwell  (in_dwell),
      .led       (led),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic request(input logic [3:0] p, input logic [2:0] d, input logic [3:0] w);
      in_valid   = 1'b1;
      in_pattern = p;
      in_duty    = d;
      in_dwell   = w;
      tick();
      in_valid   = 1'b0;
      in_pattern = 4'h0;
      in_duty    = 3'h0;
      in_dwell   = 4'h0;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b1; in_pattern = 4'hF; in_duty = 3'd7; in_dwell = 4'd1;
      tick(); tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_prio ready=%b busy=%b need ready=1 busy=0", in_ready, busy);
      end
      checks++;
      if (led !== 4'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs led=%h done=%b need led=0 done=0", led, done);
      end
      reset = 1'b0; in_valid = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle ready=%b busy=%b done=%b need 1 0 0", in_ready, busy, done);
      end
   endtask

   task automatic test_basic;
      logic [3:0] exp;
      int bad = 0;
      request(4'b1010, 3'd3, 4'd2);
      for (int i = 0; i < 16; i++) begin
         exp = ((i % 8) < 3) ? 4'b1010 : 4'b0000;
         if (busy !== 1'b1 || led !== exp || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_cyc%0d busy=%b led=%b done=%b need 1 %b 0", i, busy, led, done, exp);
         end
         tick();
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || led !== 4'h0) begin
         errors++;
         $display("FAIL basic_end busy=%b done=%b led=%b need 0 1 0000", busy, done, led);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_once done=%b need 0", done);
      end
   endtask

   task automatic test_zero_duty_dwell;
      int n = 0;
      int lit = 0;
      request(4'b1111, 3'd0, 4'd0);
      while (busy === 1'b1 && n < 100) begin
         if (led !== 4'h0) lit++;
         tick();
         n++;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL zero_len got %0d cycles need 8", n);
      end
      checks++;
      if (lit != 0) begin
         errors++;
         $display("FAIL zero_led lit %0d cycles need 0", lit);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL zero_done done=%b need 1", done);
      end
      tick();
   endtask

   task automatic test_full_duty;
      logic [3:0] exp;
      int bad = 0;
      request(4'b0110, 3'd7, 4'd1);
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 4'b0110 : 4'b0000;
         if (busy !== 1'b1 || led !== exp) begin
            bad++;
            $display("FAIL full_cyc%0d busy=%b led=%b need 1 %b", i, busy, led, exp);
         end
         in_valid   = (i < 7) ? ((i % 2) == 0) : 1'b0;
         in_pattern = 4'b1111;
         in_duty    = 3'd0;
         in_dwell   = 4'd5;
         tick();
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL full_end busy=%b done=%b need 0 1", busy, done);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || led !== 4'h0) begin
         errors++;
         $display("FAIL full_nocapture busy=%b led=%b need 0 0000", busy, led);
      end
   endtask

   task automatic test_back_to_back;
      int n = 0;
      in_valid = 1'b1; in_pattern = 4'b0001; in_duty = 3'd2; in_dwell = 4'd1;
      tick();
      in_pattern = 4'b1000; in_duty = 3'd4;
      while (busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL b2b_first_len got %0d need 8", n);
      end
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap done=%b ready=%b need 1 1", done, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || led !== 4'b1000 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second busy=%b led=%b done=%b need 1 1000 0", busy, led, done);
      end
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 8 || done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_len got %0d done=%b need 8 1", n, done);
      end
      tick();
   endtask

   task automatic test_reset_abort;
      int n = 0;
      request(4'b1111, 3'd7, 4'd4);
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (busy !== 1'b1 || led !== 4'b1111) begin
         errors++;
         $display("FAIL abort_pre busy=%b led=%b need 1 1111", busy, led);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || led !== 4'h0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_post ready=%b busy=%b led=%b done=%b need 1 0 0000 0",
                  in_ready, busy, led, done);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone done=%b busy=%b need 0 0", done, busy);
      end
      request(4'b0101, 3'd1, 4'd1);
      checks++;
      if (led !== 4'b0101) begin
         errors++;
         $display("FAIL abort_rerun_on led=%b need 0101", led);
      end
      tick();
      checks++;
      if (led !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_rerun_off led=%b busy=%b need 0000 1", led, busy);
      end
      n = 1;
      while (busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 8 || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_rerun_len got %0d done=%b need 8 1", n, done);
      end
      tick();
   endtask

   task automatic test_max_dwell;
      int n = 0;
      request(4'b0011, 3'd1, 4'd15);
      while (busy === 1'b1 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n != 120) begin
         errors++;
         $display("FAIL max_dwell_len got %0d need 120", n);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL max_dwell_done done=%b need 1", done);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_pattern = 4'h0; in_duty = 3'h0; in_dwell = 4'h0;
      test_reset();
      test_basic();
      test_zero_duty_dwell();
      test_full_duty();
      test_back_to_back();
      test_reset_abort();
      test_max_dwell();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pwm_sequencer.md
LED_PWM_SEQUENCER -- requirements
Module: led_pwm_sequencer

Interface
REQ-001 SHALL provide parameter W_LED, default 4, LED pattern width.
REQ-002 SHALL provide parameter PWM_W, default 8, PWM counter width; PWM period P = 2^PWM_W cycles.
REQ-003 SHALL provide parameter DWELL_W, default 16, dwell count width in PWM periods.
REQ-004 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  sequencer can accept a request.
REQ-008 SHALL have port in_pattern  input  W_LED  LED bits to display.
REQ-009 SHALL have port in_duty  input  PWM_W  on-time in cycles per PWM period.
REQ-010 SHALL have port in_dwell  input  DWELL_W  display length in PWM periods.
REQ-011 SHALL have port led  output  W_LED  PWM-gated LED drive.
REQ-012 SHALL have port busy  output  1  high while displaying.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement two states: IDLE and SHOW.
REQ-015 in_ready SHALL equal 1 exactly when state is IDLE; busy SHALL equal 1 exactly when state is SHOW.
REQ-016 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_pattern, in_duty, in_dwell captured into internal registers; state -> SHOW.
REQ-017 in_valid while in SHOW SHALL be ignored (no capture, no state effect); inputs need not be held after accept.
REQ-018 On accept, pwm_cnt (PWM_W bits) and period_cnt (DWELL_W bits) SHALL load 0.
REQ-019 In SHOW, pwm_cnt SHALL increment by 1 each cycle, wrapping from 2^PWM_W-1 to 0; period_cnt SHALL increment on each wrap.
REQ-020 Effective dwell D SHALL be the captured in_dwell, with 0 treated as 1.
REQ-021 SHOW SHALL last exactly D*P cycles; in the cycle where pwm_cnt=2^PWM_W-1 and period_cnt=D-1, next state SHALL be IDLE.
REQ-022 led SHALL be combinational from registers: captured pattern when state=SHOW and pwm_cnt < captured duty (unsigned), else all zeros.
REQ-023 duty=0 SHALL give led=0 for the whole SHOW; duty=2^PWM_W-1 SHALL give on for P-1 of P cycles each period.
REQ-024 done SHALL be a registered pulse, high for exactly the first IDLE cycle after SHOW ends, otherwise 0.
REQ-025 Back-to-back: a request valid in the done cycle SHALL be accepted, giving minimum one IDLE cycle between consecutive SHOWs.
REQ-026 period_cnt SHALL not overflow: in_dwell=2^DWELL_W-1 SHALL give exactly (2^DWELL_W-1)*P SHOW cycles.

Reset
REQ-027 With reset=1 at a rising edge, state SHALL become IDLE and pwm_cnt, period_cnt, captured pattern/duty/dwell, and done SHALL become 0, regardless of in_valid.
REQ-028 After reset: in_ready=1, busy=0, led=0, done=0.
REQ-029 Reset during SHOW SHALL abort the display with no done pulse; led=0 from the next cycle.
REQ-030 Reset SHALL take priority over accept in the same cycle.

Verification (PWM_W=3, P=8, W_LED=4)
REQ-031 Accept pattern=4'b1010, duty=3, dwell=2 -> busy high 16 cycles; led=1010 on pwm_cnt 0..2, 0000 on 3..7, each period; done pulses once in cycle 17.
REQ-032 dwell=0, duty=0, pattern=4'b1111 -> SHOW lasts 8 cycles, led=0 throughout, done pulses once.
REQ-033 duty=7, dwell=1 -> led=pattern for 7 cycles, 0 for 1 cycle; in_valid toggled during SHOW causes no capture.
REQ-034 in_valid held high continuously, two requests -> second accepted in the done cycle; exactly one IDLE cycle between the two busy windows.
REQ-035 Reset asserted 5 cycles into a dwell=4 SHOW -> next cycle in_ready=1, busy=0, led=0, no done pulse; a subsequent request runs normally.
